// File: rtl/add_4_3_pkg.sv
// Shared widths for the add_4_3 registered ripple-carry adder.
package add_4_3_pkg;

    localparam int A_W_DEF   = 4;
    localparam int B_W_DEF   = 3;
    localparam int SUM_W_DEF = A_W_DEF + 1;

    // Result width for any operand-A width: one extra bit for the carry out.
    function automatic int sum_width(input int a_w);
        return a_w + 1;
    endfunction

endpackage

// File: rtl/add_4_3_full_adder.sv
// One-bit combinational full adder, the cell of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/add_4_3.sv
// Unsigned A + zero-extended B through a full-adder ripple chain, registered
// once so that no input reaches an output combinationally.
module add_4_3
    import add_4_3_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      IN_VALID,
    input  logic [A_W-1:0]            A,
    input  logic [B_W-1:0]            B,
    output logic                      OUT_VALID,
    output logic [sum_width(A_W)-1:0] SUM
);

    logic [A_W-1:0] b_ext;
    logic [A_W-1:0] sum_bits;
    logic [A_W:0]   carry;

    // Cast zero-extends and stays legal when B_W equals A_W.
    assign b_ext    = A_W'(B);
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < A_W; i++) begin : g_ripple
        full_adder u_fa (
            .a  (A[i]),
            .b  (b_ext[i]),
            .ci (carry[i]),
            .s  (sum_bits[i]),
            .co (carry[i+1])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
            SUM       <= '0;
        end else begin
            OUT_VALID <= IN_VALID;
            if (IN_VALID) begin
                SUM <= {carry[A_W], sum_bits};
            end
        end
    end

endmodule

// File: tb/tb_add_4_3.sv
// Scoreboard bench for add_4_3: expected sums are queued at launch and
// popped one cycle later when the result should be on SUM.
module tb_add_4_3;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       IN_VALID = 1'b0;
    logic [3:0] A = '0;
    logic [2:0] B = '0;
    logic       OUT_VALID;
    logic [4:0] SUM;

    logic [4:0] sb[$];
    int         n_checks = 0;
    int         n_fail = 0;

    add_4_3 dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .A         (A),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .SUM       (SUM)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of stimulus and advance to just after the capturing edge.
    task automatic step(input logic v, input logic [3:0] a, input logic [2:0] b,
                        input logic [4:0] exp);
        @(negedge CLK);
        IN_VALID = v;
        A        = a;
        B        = b;
        if (v) sb.push_back(exp);
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [4:0] pop_exp();
        if (sb.size() == 0) return 5'bx;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (SUM !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_sum: got %b, required 00000", SUM);
        end
        n_checks++;
        if (OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b, required 0", OUT_VALID);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_vectors();
        logic [3:0] ta[4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
        logic [2:0] tb[4] = '{3'b000, 3'b001, 3'b001, 3'b011};
        logic [4:0] te[4] = '{5'b00000, 5'b00010, 5'b00100, 5'b01010};
        logic [4:0] exp;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ta[i], tb[i], te[i]);
            exp = pop_exp();
            n_checks++;
            if (SUM !== exp || OUT_VALID !== 1'b1) begin
                n_fail++;
                $display("FAIL vector_%0d: got sum=%b valid=%b, required sum=%b valid=1",
                         i, SUM, OUT_VALID, exp);
            end
        end
    endtask

    task automatic test_max_operands();
        logic [4:0] exp;
        step(1'b1, 4'b1111, 3'b111, 5'b10110);
        exp = pop_exp();
        n_checks++;
        if (SUM !== exp || OUT_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL max_operands: got sum=%b valid=%b, required sum=%b valid=1",
                     SUM, OUT_VALID, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        step(1'b1, 4'b0111, 3'b011, 5'b01010);
        exp = pop_exp();
        n_checks++;
        if (SUM !== exp || OUT_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got sum=%b valid=%b, required sum=%b valid=1",
                     SUM, OUT_VALID, exp);
        end
        step(1'b1, 4'b1111, 3'b111, 5'b10110);
        exp = pop_exp();
        n_checks++;
        if (SUM !== exp || OUT_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got sum=%b valid=%b, required sum=%b valid=1",
                     SUM, OUT_VALID, exp);
        end
        step(1'b0, 4'b0101, 3'b010, 5'b00000);
        n_checks++;
        if (SUM !== 5'b10110 || OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_hold: got sum=%b valid=%b, required sum=10110 valid=0",
                     SUM, OUT_VALID);
        end
    endtask

    task automatic test_random();
        logic [4:0] last = 5'b10110;
        logic [4:0] exp;
        logic [3:0] a;
        logic [2:0] b;
        logic       v;
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 3'($urandom_range(0, 7));
            v = 1'($urandom_range(0, 3) != 0);
            step(v, a, b, {1'b0, a} + {2'b00, b});
            exp = v ? pop_exp() : last;
            n_checks++;
            if (SUM !== exp || OUT_VALID !== v) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h v=%b got sum=%b valid=%b, required sum=%b valid=%b",
                         i, a, b, v, SUM, OUT_VALID, exp, v);
            end
            last = exp;
        end
    endtask

    task automatic test_reset_inflight();
        logic [4:0] exp;
        step(1'b1, 4'b1001, 3'b110, 5'b01111);
        void'(pop_exp());
        // Next pair is sampled but reset lands before it would be seen.
        @(negedge CLK);
        IN_VALID = 1'b1;
        A        = 4'b1100;
        B        = 3'b101;
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        IN_VALID = 1'b0;
        #1;
        n_checks++;
        if (SUM !== 5'b00000 || OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got sum=%b valid=%b, required sum=00000 valid=0",
                     SUM, OUT_VALID);
        end
        sb.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (SUM !== 5'b00000 || OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: got sum=%b valid=%b, required sum=00000 valid=0",
                     SUM, OUT_VALID);
        end
        step(1'b1, 4'b0110, 3'b101, 5'b01011);
        exp = pop_exp();
        n_checks++;
        if (SUM !== exp || OUT_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_result: got sum=%b valid=%b, required sum=%b valid=1",
                     SUM, OUT_VALID, exp);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_max_operands();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
